// File: rtl/lorenz_pkg.sv
// Shared types for the lorenz run sequencer.
//   fixed_t     : signed fixed-point word, Q(SIZE-PNT).PNT
//   run_state_e : run sequencer states
//   sample_t    : one captured sample {x, y, z, idx}
package lorenz_pkg;
  localparam int SIZE     = 64;
  localparam int PNT      = 48;
  localparam int FAC_SIZE = 3;
  localparam int CNT_W    = 32;

  typedef logic signed [SIZE-1:0] fixed_t;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN, DONE} run_state_e;

  typedef struct packed {
    fixed_t           x;
    fixed_t           y;
    fixed_t           z;
    logic [CNT_W-1:0] idx;
  } sample_t;
endpackage

// File: rtl/lorenz_sample_fifo.sv
// Small sample FIFO for the run sequencer (power-of-2 depth, flushable).
// Ports: clock, reset (sync, active low), flush (empties the FIFO),
//   push/din write, pop/dout read (dout = head), full, empty.
// Push while full is legal only together with pop (the popped slot is reused).
module lorenz_sample_fifo
  import lorenz_pkg::*;
#(
  parameter int FIFO_D = 4
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  sample_t       mem [FIFO_D];
  logic [AW:0]   wr_ptr, rd_ptr;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/lorenz_run_ctrl.sv
// Run sequencer for the lorenz DDA integrator.
// Latches a run config, holds lorenz in reset while driving its inputs, releases
// it for a bounded run, captures every DECIM-th step and streams captures out.
// Ports:
//   clock, reset        : clock, synchronous active-low reset
//   cfg_valid/cfg_ready : config handshake (ready only in IDLE), cfg_* payload
//   start, abort        : run control pulses
//   lz_reset, lz_*      : drive lorenz (lz_reset active low), lz_x/y/z its state
//   smp_valid/smp_ready : sample stream handshake, smp_x/y/z/idx payload
//   busy, done, drop_cnt: status
// Build option: define LORENZ_RUN_FIFO_EN for a FIFO_D-deep sample FIFO;
// otherwise the buffer is a single output register. Ports are identical.
module lorenz_run_ctrl #(
  parameter int SIZE     = lorenz_pkg::SIZE,
  parameter int PNT      = lorenz_pkg::PNT,
  parameter int FAC_SIZE = lorenz_pkg::FAC_SIZE,
  parameter int CNT_W    = lorenz_pkg::CNT_W,
  parameter int RST_CYC  = 2,
  parameter int FIFO_D   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SIZE-1:0]     cfg_x0,
  input  logic [SIZE-1:0]     cfg_y0,
  input  logic [SIZE-1:0]     cfg_z0,
  input  logic [SIZE-1:0]     cfg_sigma,
  input  logic [SIZE-1:0]     cfg_rho,
  input  logic [SIZE-1:0]     cfg_beta,
  input  logic [FAC_SIZE:0]   cfg_factor,
  input  logic [CNT_W-1:0]    cfg_nsamp,
  input  logic [CNT_W-1:0]    cfg_decim,
  input  logic                start,
  input  logic                abort,
  output logic                lz_reset,
  output logic [SIZE-1:0]     lz_x0,
  output logic [SIZE-1:0]     lz_y0,
  output logic [SIZE-1:0]     lz_z0,
  output logic [SIZE-1:0]     lz_sigma,
  output logic [SIZE-1:0]     lz_rho,
  output logic [SIZE-1:0]     lz_beta,
  output logic [FAC_SIZE:0]   lz_factor,
  input  logic [SIZE-1:0]     lz_x,
  input  logic [SIZE-1:0]     lz_y,
  input  logic [SIZE-1:0]     lz_z,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [SIZE-1:0]     smp_x,
  output logic [SIZE-1:0]     smp_y,
  output logic [SIZE-1:0]     smp_z,
  output logic [CNT_W-1:0]    smp_idx,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    drop_cnt
);
  import lorenz_pkg::*;

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  // Elaboration-time guard on parameter combinations.
  if (PNT >= SIZE || RST_CYC < 1 || FIFO_D < 2 || (FIFO_D & (FIFO_D - 1)) != 0) begin : g_bad_param
    $error("lorenz_run_ctrl: illegal parameter combination");
  end

  run_state_e        state, state_nx;
  logic [RC_W-1:0]   settle_cnt;
  logic [SIZE-1:0]   sh_x0, sh_y0, sh_z0, sh_sigma, sh_rho, sh_beta;
  logic [FAC_SIZE:0] sh_factor;
  logic [CNT_W-1:0]  sh_nsamp, sh_decim, r_nsamp, r_decim, phase, cap_cnt;
  logic              flush, capture, pop, buf_full, buf_empty, space;
  logic              cap_ok, cap_drop, last_cap;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign lz_reset  = (state == RUN);

  // abort is a no-op in IDLE, so start always wins there.
  assign flush    = (state != IDLE) && abort;
  // phase runs 1..r_decim, so captures land on steps D, 2D, ...
  assign capture  = (state == RUN) && !abort && (phase == r_decim);
  assign pop      = smp_valid && smp_ready;
  // A same-cycle pop frees the slot, so a full buffer still accepts.
  assign space    = !buf_full || smp_ready;
  assign cap_ok   = capture && space;
  assign cap_drop = capture && !space;
  assign last_cap = cap_ok && (r_nsamp != '0) && ((cap_cnt + CNT_W'(1)) == r_nsamp);

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nx = LOAD;
        LOAD:    state_nx = SETTLE;
        SETTLE:  if (settle_cnt == RC_W'(RST_CYC - 1)) state_nx = RUN;
        RUN:     if (last_cap) state_nx = DRAIN;
        DRAIN:   if (buf_empty) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      sh_x0      <= '0;  sh_y0  <= '0;  sh_z0   <= '0;
      sh_sigma   <= '0;  sh_rho <= '0;  sh_beta <= '0;
      sh_factor  <= '0;  sh_nsamp <= '0; sh_decim <= '0;
      lz_x0      <= '0;  lz_y0  <= '0;  lz_z0   <= '0;
      lz_sigma   <= '0;  lz_rho <= '0;  lz_beta <= '0;
      lz_factor  <= '0;
      r_nsamp    <= '0;
      r_decim    <= CNT_W'(1);
      phase      <= CNT_W'(1);
      cap_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (cfg_valid && cfg_ready) begin
        sh_x0    <= cfg_x0;    sh_y0  <= cfg_y0;  sh_z0   <= cfg_z0;
        sh_sigma <= cfg_sigma; sh_rho <= cfg_rho; sh_beta <= cfg_beta;
        sh_factor <= cfg_factor; sh_nsamp <= cfg_nsamp; sh_decim <= cfg_decim;
      end
      // Run config is taken on the start edge so lz_* are valid during LOAD.
      if (state == IDLE && start) begin
        lz_x0    <= sh_x0;    lz_y0  <= sh_y0;  lz_z0   <= sh_z0;
        lz_sigma <= sh_sigma; lz_rho <= sh_rho; lz_beta <= sh_beta;
        lz_factor <= sh_factor;
        r_nsamp  <= sh_nsamp;
        r_decim  <= (sh_decim == '0) ? CNT_W'(1) : sh_decim;
        cap_cnt  <= '0;
        drop_cnt <= '0;
      end
      settle_cnt <= (state == SETTLE) ? settle_cnt + RC_W'(1) : '0;
      if (state == RUN) phase <= (phase == r_decim) ? CNT_W'(1) : phase + CNT_W'(1);
      else              phase <= CNT_W'(1);
      if (cap_ok) cap_cnt <= cap_cnt + CNT_W'(1);
      if (cap_drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef LORENZ_RUN_FIFO_EN
  sample_t push_s, head_s;
  logic    fifo_empty;

  assign push_s.x   = lz_x;
  assign push_s.y   = lz_y;
  assign push_s.z   = lz_z;
  assign push_s.idx = cap_cnt;

  lorenz_sample_fifo #(.FIFO_D(FIFO_D)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (cap_ok),
    .pop   (pop),
    .din   (push_s),
    .dout  (head_s),
    .full  (buf_full),
    .empty (fifo_empty)
  );

  assign buf_empty = fifo_empty;
  assign smp_valid = !fifo_empty;
  assign smp_x     = head_s.x;
  assign smp_y     = head_s.y;
  assign smp_z     = head_s.z;
  assign smp_idx   = head_s.idx;
`else
  assign buf_full  = smp_valid;
  assign buf_empty = !smp_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      smp_valid <= 1'b0;
      smp_x     <= '0;
      smp_y     <= '0;
      smp_z     <= '0;
      smp_idx   <= '0;
    end else if (flush) begin
      smp_valid <= 1'b0;
    end else if (cap_ok) begin
      smp_valid <= 1'b1;
      smp_x     <= lz_x;
      smp_y     <= lz_y;
      smp_z     <= lz_z;
      smp_idx   <= cap_cnt;
    end else if (pop) begin
      smp_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_lorenz_run_ctrl.sv
// Scoreboard bench for lorenz_run_ctrl. A stand-in integrator steps x+1, y+2,
// z-1 per released cycle, so the value at step s is x0+(s-1), y0+2(s-1), z0-(s-1).
module tb_lorenz_run_ctrl;
  localparam logic [63:0] X0   = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] Y0   = 64'h0000_1999_9999_9999;
  localparam logic [63:0] Z0   = 64'h0019_0000_0000_0000;
  localparam logic [63:0] SIG  = 64'h000A_0000_0000_0000;
  localparam logic [63:0] RHO  = 64'h001C_0000_0000_0000;
  localparam logic [63:0] BETA = 64'h0002_AAAA_AAAA_AAAA;
`ifdef LORENZ_RUN_FIFO_EN
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, cfg_valid, cfg_ready, start, abort, lz_reset;
  logic        smp_valid, smp_ready, busy, done;
  logic [63:0] cfg_x0, cfg_y0, cfg_z0, cfg_sigma, cfg_rho, cfg_beta;
  logic [63:0] lz_x0, lz_y0, lz_z0, lz_sigma, lz_rho, lz_beta;
  logic [63:0] lz_x, lz_y, lz_z, smp_x, smp_y, smp_z;
  logic [3:0]  cfg_factor, lz_factor;
  logic [31:0] cfg_nsamp, cfg_decim, smp_idx, drop_cnt;

  always #5 clock = ~clock;

  lorenz_run_ctrl dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_z0(cfg_z0), .cfg_sigma(cfg_sigma),
    .cfg_rho(cfg_rho), .cfg_beta(cfg_beta), .cfg_factor(cfg_factor),
    .cfg_nsamp(cfg_nsamp), .cfg_decim(cfg_decim), .start(start), .abort(abort),
    .lz_reset(lz_reset), .lz_x0(lz_x0), .lz_y0(lz_y0), .lz_z0(lz_z0),
    .lz_sigma(lz_sigma), .lz_rho(lz_rho), .lz_beta(lz_beta), .lz_factor(lz_factor),
    .lz_x(lz_x), .lz_y(lz_y), .lz_z(lz_z), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z), .smp_idx(smp_idx),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  // Stand-in integrator: loads x0/y0/z0 while held in reset, steps when released.
  logic [63:0] mx, my, mz;
  always @(posedge clock) begin
    if (!lz_reset) begin
      mx <= lz_x0; my <= lz_y0; mz <= lz_z0;
    end else begin
      mx <= mx + 64'd1; my <= my + 64'd2; mz <= mz - 64'd1;
    end
  end
  assign lz_x = mx;
  assign lz_y = my;
  assign lz_z = mz;

  typedef struct { logic [63:0] x, y, z; logic [31:0] idx; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, done_cnt = 0, pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [63:0] x0, input logic [63:0] y0, input logic [63:0] z0,
                          input int s, input int idx);
    exp_t e;
    logic [63:0] d;
    d = 64'(s - 1);
    e.x = x0 + d; e.y = y0 + (d << 1); e.z = z0 - d; e.idx = 32'(idx);
    exp_q.push_back(e);
  endtask

  // Monitor: pops on each transfer; while stalled, the held sample must be the queue head.
  always @(negedge clock) begin
    if (done) done_cnt <= done_cnt + 1;
    if (smp_valid && smp_ready) begin
      chk("smp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("smp_x", smp_x, mon_e.x);
        chk("smp_y", smp_y, mon_e.y);
        chk("smp_z", smp_z, mon_e.z);
        chk("smp_idx", 64'(smp_idx), 64'(mon_e.idx));
        pops <= pops + 1;
      end
    end else if (smp_valid && exp_q.size() != 0) begin
      chk("hold_x", smp_x, exp_q[0].x);
      chk("hold_idx", 64'(smp_idx), 64'(exp_q[0].idx));
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_cfg(input logic [63:0] x0, input int ns, input int dc);
    cfg_valid = 1'b1; cfg_x0 = x0; cfg_y0 = Y0; cfg_z0 = Z0;
    cfg_sigma = SIG; cfg_rho = RHO; cfg_beta = BETA; cfg_factor = 4'd8;
    cfg_nsamp = 32'(ns); cfg_decim = 32'(dc);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (!lz_reset && n < 20) begin n++; tick(); end
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 1000) begin c++; tick(); end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_idle_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_lz_reset", 64'(lz_reset), 64'd0);
    chk("rst_lz_x0", lz_x0, 64'd0);
    chk("rst_smp_valid", 64'(smp_valid), 64'd0);
    chk("rst_smp_x", smp_x, 64'd0);
    chk("rst_smp_idx", 64'(smp_idx), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
  endtask

  task automatic run_basic(input int ns, input int dc);
    int n, d0;
    send_cfg(X0, ns, dc);
    smp_ready = 1'b1;
    for (int k = 0; k < ns; k++) push_exp(X0, Y0, Z0, (k + 1) * dc, k);
    start = 1'b1; tick(); start = 1'b0;
    chk("lz_x0", lz_x0, X0);
    chk("lz_y0", lz_y0, Y0);
    chk("lz_z0", lz_z0, Z0);
    chk("lz_sigma", lz_sigma, SIG);
    chk("lz_rho", lz_rho, RHO);
    chk("lz_beta", lz_beta, BETA);
    chk("lz_factor", 64'(lz_factor), 64'd8);
    chk("cfg_ready_load", 64'(cfg_ready), 64'd0);
    chk("busy_load", 64'(busy), 64'd1);
    d0 = done_cnt;
    wait_run(n);
    chk("lz_reset_low_cycles", 64'(n), 64'd3);
    wait_done();
    tick();
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("drop_cnt_run", 64'(drop_cnt), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0, p0, s;
    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; smp_ready = 1'b0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_z0 = '0; cfg_sigma = '0; cfg_rho = '0; cfg_beta = '0;
    cfg_factor = '0; cfg_nsamp = '0; cfg_decim = '0;
    repeat (3) tick();
    check_idle_reset();
    reset = 1'b1; tick();

    // 1: decim 1, four samples at steps 1..4
    run_basic(4, 1);
    // 2: decim 5, samples at steps 5, 10, 15
    run_basic(3, 5);

    // 3: backpressure for steps 1..10, six accepted captures end the run
    send_cfg(X0, 6, 1);
    smp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s = FIFO_BUILD ? ((k < 4) ? k + 1 : k + 7) : ((k == 0) ? 1 : k + 10);
      push_exp(X0, Y0, Z0, s, k);
    end
    start = 1'b1; tick(); start = 1'b0;
    wait_run(n);
    repeat (10) tick();
    smp_ready = 1'b1;
    wait_done();
    chk("bp_drop_cnt", 64'(drop_cnt), FIFO_BUILD ? 64'd6 : 64'd9);
    tick();
    chk("bp_queue_drained", 64'(exp_q.size()), 64'd0);

    // 4: abort in RUN with a pending sample, then a clean run
    send_cfg(X0, 0, 1);
    smp_ready = 1'b0;
    push_exp(X0, Y0, Z0, 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    wait_run(n);
    repeat (3) tick();
    chk("abort_pre_valid", 64'(smp_valid), 64'd1);
    d0 = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_lz_reset", 64'(lz_reset), 64'd0);
    chk("abort_smp_valid", 64'(smp_valid), 64'd0);
    chk("abort_drop_kept", 64'(drop_cnt), FIFO_BUILD ? 64'd0 : 64'd2);
    tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    exp_q.delete();
    run_basic(2, 1);

    // 5: start/cfg during RUN are ignored; reset mid-RUN
    send_cfg(X0, 6, 1);
    smp_ready = 1'b1;
    for (int k = 0; k < 6; k++) push_exp(X0, Y0, Z0, k + 1, k);
    start = 1'b1; tick(); start = 1'b0;
    wait_run(n);
    tick();
    chk("run_cfg_ready", 64'(cfg_ready), 64'd0);
    cfg_valid = 1'b1; cfg_x0 = 64'h0000_1234_0000_0000; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("run_lz_reset_kept", 64'(lz_reset), 64'd1);
    chk("run_lz_x0_kept", lz_x0, X0);
    wait_done();
    tick();
    for (int k = 0; k < 6; k++) push_exp(X0, Y0, Z0, k + 1, k);
    start = 1'b1; tick(); start = 1'b0;
    chk("ignored_cfg_x0", lz_x0, X0);
    wait_run(n);
    repeat (2) tick();
    reset = 1'b0; tick();
    check_idle_reset();
    exp_q.delete();
    tick();
    reset = 1'b1; tick();

    // 6: no config after reset -> zeros, nsamp 0 free-runs, decim 0 acts as 1
    smp_ready = 1'b1;
    for (int k = 0; k < 130; k++) push_exp(64'd0, 64'd0, 64'd0, k + 1, k);
    start = 1'b1; tick(); start = 1'b0;
    chk("zero_cfg_lz_x0", lz_x0, 64'd0);
    wait_run(n);
    d0 = done_cnt;
    p0 = pops;
    repeat (110) tick();
    chk("free_run_busy", 64'(busy), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("free_run_pops", 64'((pops - p0) >= 100), 64'd1);
    chk("free_run_abort_busy", 64'(busy), 64'd0);
    tick();
    chk("free_run_no_done", 64'(done_cnt - d0), 64'd0);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
